// File: rtl/edge_event_if.sv
// Event handshake bundle between the edge arbiter (master) and its consumer (slave).
// Carries the offered channel index alongside the valid/ready pair.
interface edge_event_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector with one pending event per channel, shared through a round-robin valid/ready port.
// Define EDGE_ARB_OVF_EN to build the sticky per-channel overflow flags; otherwise ovf reads 0.
module edge_event_arbiter #(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] data_in,
    input  logic [N_CH-1:0] ch_en,
    edge_event_if.master    evt,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] d_prev_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] evt_ch_q, evt_ch_d;

    logic [N_CH-1:0] edge_det;
    logic [N_CH-1:0] offered;
    logic [N_CH-1:0] accepted;
    logic [N_CH-1:0] cand;
    logic            accept;
    logic [CH_W-1:0] sel_idx;
    logic            sel_found;
    logic [CH_W:0]   scan_sum;
    logic [CH_W-1:0] scan_idx;

    always_comb begin
        edge_det = data_in & ~d_prev_q & ch_en;
        accept   = (state_q == OFFER) && evt.evt_ready;
        offered  = '0;
        for (int i = 0; i < N_CH; i++) begin
            offered[i] = (state_q == OFFER) && (evt_ch_q == CH_W'(i));
        end
        accepted = offered & {N_CH{accept}};
    end

    // A channel whose enable has dropped is no longer a candidate, so it can never be
    // picked in the same cycle its pending bit is being cleared.
    always_comb begin
        cand      = pending_q & ch_en;
        sel_idx   = '0;
        sel_found = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
            if (scan_sum >= (CH_W + 1)'(N_CH)) begin
                scan_sum = scan_sum - (CH_W + 1)'(N_CH);
            end
            scan_idx = scan_sum[CH_W-1:0];
            if (!sel_found && cand[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // An edge always re-arms the channel, so an edge landing on the acceptance cycle survives.
    always_comb begin
        pending_d = edge_det | (pending_q & ~accepted & (ch_en | offered));
    end

    always_comb begin
        state_d  = state_q;
        evt_ch_d = evt_ch_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    evt_ch_d = sel_idx;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (evt_ch_q == CH_W'(N_CH - 1)) ? '0 : evt_ch_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            d_prev_q  <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            evt_ch_q  <= '0;
        end else begin
            state_q   <= state_d;
            d_prev_q  <= data_in;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            evt_ch_q  <= evt_ch_d;
        end
    end

`ifdef EDGE_ARB_OVF_EN
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [N_CH-1:0] ovf_cond;

    // Set has priority over clear so an overflow coinciding with ovf_clr is not lost.
    always_comb begin
        ovf_cond = edge_det & pending_q & ~accepted;
        ovf_d    = (ovf_clr ? '0 : ovf_q) | ovf_cond;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = '0;
`endif

    assign pending       = pending_q;
    assign evt.evt_valid = (state_q == OFFER);
    assign evt.evt_ch    = evt_ch_q;
endmodule
